// File: rtl/freqmeter_pkg.sv
// Shared types and default sizing for the frequency meter.
package freqmeter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH   = 28;
  localparam logic [27:0] DEF_TIMEOUT = 28'd100000000;

endpackage

// File: rtl/edge_detector.sv
// Edge detector for the measured signal. Optional FREQMETER_SYNC_EN puts a
// two-flop synchronizer in front of the previous-value register.
module edge_detector (
  input  logic clock_in,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s;
  logic prev;

`ifdef FREQMETER_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer; sync_q[1] is the metastability-safe sample.
  always_ff @(posedge clock_in) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], d};
  end

  assign s = sync_q[1];
`else
  // Input already lives in this clock domain.
  assign s = d;
`endif

  // Previous sample of s for edge comparison.
  always_ff @(posedge clock_in) begin
    if (reset) prev <= 1'b0;
    else       prev <= s;
  end

  assign rise = s & ~prev;
  assign fall = ~s & prev;

endmodule

// File: rtl/frequency_meter.sv
// Measures period and high time of a slow square wave in clock_in cycles.
// Build option: FREQMETER_SYNC_EN adds an input synchronizer (+2 cycles latency).
module frequency_meter
  import freqmeter_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(DEF_TIMEOUT)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             signal_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid_out,
  output logic             timeout_out
);

  localparam logic [WIDTH-1:0] TO_LAST = TIMEOUT - WIDTH'(1);

  logic             rise, fall;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic [WIDTH-1:0] high_shadow, high_shadow_nxt;
  logic [WIDTH-1:0] period_nxt, high_nxt;
  logic             valid_nxt, timeout_nxt;

  edge_detector u_edge (
    .clock_in (clock_in),
    .reset    (reset),
    .d        (signal_in),
    .rise     (rise),
    .fall     (fall)
  );

  // cnt never exceeds TIMEOUT-1, so the +1 cannot overflow WIDTH.
  assign cnt_inc = cnt + WIDTH'(1);

  // Next-state logic: counting, edge capture and timeout.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    high_shadow_nxt = high_shadow;
    period_nxt      = period_out;
    high_nxt        = high_out;
    valid_nxt       = 1'b0;
    timeout_nxt     = timeout_out;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rise) begin
          state_nxt   = MEASURE;
          timeout_nxt = 1'b0;
        end
      end
      MEASURE: begin
        cnt_nxt = cnt_inc;
        if (fall) high_shadow_nxt = cnt_inc;
        // A rise on the last allowed count still yields a valid period.
        if (rise) begin
          period_nxt = cnt_inc;
          high_nxt   = high_shadow;
          valid_nxt  = 1'b1;
          cnt_nxt    = '0;
        end else if (cnt == TO_LAST) begin
          timeout_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      high_shadow <= '0;
      period_out  <= '0;
      high_out    <= '0;
      valid_out   <= 1'b0;
      timeout_out <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      high_shadow <= high_shadow_nxt;
      period_out  <= period_nxt;
      high_out    <= high_nxt;
      valid_out   <= valid_nxt;
      timeout_out <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_frequency_meter.sv
// Scoreboard bench for frequency_meter with a timestamp-based reference model.
module tb_frequency_meter;

  localparam int WIDTH = 28;
  localparam int TMO   = 16;
  localparam int N     = 16384;
`ifdef FREQMETER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int cyc;
    int per;
    int hi;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig = 1'b0;
  logic [WIDTH-1:0] period_out, high_out;
  logic             valid_out, timeout_out;

  frequency_meter #(.WIDTH(WIDTH), .TIMEOUT(28'd16)) dut (
    .clock_in    (clk),
    .reset       (rst),
    .signal_in   (sig),
    .period_out  (period_out),
    .high_out    (high_out),
    .valid_out   (valid_out),
    .timeout_out (timeout_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  bit   ex_to [N];
  int   ex_per[N];
  int   ex_hi [N];

  // Reference model state: timestamps of edges, not counters.
  bit m_prev = 0, armed = 0, to = 0;
  int last_rise = 0, last_fall = 0, cur_per = 0, cur_hi = 0;

  function automatic void put(input int idx);
    if (idx < N) begin
      ex_to[idx]  = to;
      ex_per[idx] = cur_per;
      ex_hi[idx]  = cur_hi;
    end
  endfunction

  function automatic void chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp_v);
    end
  endfunction

  // Drive one clock of input and advance the model for that edge.
  task automatic drive(input bit v, input bit r);
    int e;
    e   = cyc + 1;
    sig = v;
    rst = r;
    if (r) begin
      armed = 0; to = 0; m_prev = 0; cur_per = 0; cur_hi = 0;
      for (int k = 0; k <= LAT; k++) put(e + k);
    end else begin
      if (v && !m_prev) begin
        if (armed) begin
          cur_per = e - last_rise;
          cur_hi  = last_fall - last_rise;
          q.push_back('{e + LAT, cur_per, cur_hi});
        end
        armed = 1; last_rise = e; to = 0;
      end else begin
        if (!v && m_prev && armed) last_fall = e;
        if (armed && (e - last_rise) == TMO) begin
          to = 1; armed = 0;
        end
      end
      m_prev = v;
      put(e + LAT);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) drive(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) drive(1'b0, 1'b0);
    end
  endtask

  // Monitor: held outputs every cycle, valid pulses against the queue.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < N) begin
      chk("timeout_out", int'(timeout_out), int'(ex_to[cyc]));
      chk("period_hold", int'(period_out), ex_per[cyc]);
      chk("high_hold", int'(high_out), ex_hi[cyc]);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("valid_missing", 0, 1);
        void'(q.pop_front());
      end
      if (valid_out) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
          chk("valid_period", int'(period_out), q[0].per);
          chk("valid_high", int'(high_out), q[0].hi);
          void'(q.pop_front());
        end else begin
          chk("valid_spurious", 1, 0);
        end
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        chk("valid_missing", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    chk("rst_period", int'(period_out), 0);
    chk("rst_high", int'(high_out), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_timeout", int'(timeout_out), 0);
    drive(1'b0, 1'b0);

    // Divide-by-4 style wave.
    burst(0, 2, 1);
    burst(2, 2, 8);
    // 3 high, 7 low.
    burst(3, 7, 5);
    // Lone rise then held low long enough to time out, then resume.
    burst(1, 25, 1);
    burst(2, 2, 4);
    // Period exactly TIMEOUT: rise wins over the timeout.
    burst(5, 11, 3);
    // Shortest period.
    burst(1, 1, 6);
    // Randomized waves, occasionally long lows that time out.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0)
        burst(int'($urandom_range(1, 4)), int'($urandom_range(13, 22)), 1);
      else
        burst(int'($urandom_range(1, 8)), int'($urandom_range(1, 10)), 1);
    end

    // Reset in the middle of a period.
    burst(0, 4, 1);
    burst(2, 2, 3);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    chk("midrst_period", int'(period_out), 0);
    chk("midrst_high", int'(high_out), 0);
    chk("midrst_valid", int'(valid_out), 0);
    chk("midrst_timeout", int'(timeout_out), 0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    burst(2, 2, 4);
    burst(3, 7, 2);

    for (int i = 0; i < LAT + 4; i++) drive(1'b0, 1'b0);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
